// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit saturating-counter branch history table with fetch redirect and branch statistics.
// Optional gshare indexing is enabled by defining BRANCH_GSHARE_EN.
module branch_predictor_bht #(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           pc_F,
    output logic                  pred_taken_F,
    output logic [INDEX_BITS-1:0] pred_ghr_F,
    input  logic                  update_valid_M,
    input  logic [31:0]           update_pc_M,
    input  logic                  update_taken_M,
    input  logic                  update_predicted_M,
    input  logic [INDEX_BITS-1:0] update_ghr_M,
    input  logic                  branch_redirect_M,
    input  logic [31:0]           branch_dest_M,
    output logic                  redirect_valid_F,
    output logic [31:0]           redirect_pc_F,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [1:0]            table_d [ENTRIES];
    logic                  redirect_valid_q, redirect_valid_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;
    logic [31:0]           branch_cnt_q, branch_cnt_d;
    logic [31:0]           mispredict_cnt_q, mispredict_cnt_d;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic [1:0]            upd_entry;

`ifdef BRANCH_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;
    logic                  unused_bits;

    assign lookup_idx  = pc_F[INDEX_BITS+1:2] ^ ghr_q;
    assign update_idx  = update_pc_M[INDEX_BITS+1:2] ^ update_ghr_M;
    assign pred_ghr_F  = ghr_q;
    assign unused_bits = ^{pc_F[31:INDEX_BITS+2], pc_F[1:0],
                           update_pc_M[31:INDEX_BITS+2], update_pc_M[1:0]};

    always_comb begin
        ghr_d = ghr_q;
        if (update_valid_M) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], update_taken_M};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic unused_bits;

    assign lookup_idx  = pc_F[INDEX_BITS+1:2];
    assign update_idx  = update_pc_M[INDEX_BITS+1:2];
    assign pred_ghr_F  = '0;
    assign unused_bits = ^{pc_F[31:INDEX_BITS+2], pc_F[1:0],
                           update_pc_M[31:INDEX_BITS+2], update_pc_M[1:0],
                           update_ghr_M};
`endif

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign pred_taken_F = table_q[lookup_idx][1];
    assign upd_entry    = table_q[update_idx];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        if (update_valid_M) begin
            if (update_taken_M) begin
                table_d[update_idx] = (upd_entry == 2'b11) ? 2'b11 : upd_entry + 2'b01;
            end else begin
                table_d[update_idx] = (upd_entry == 2'b00) ? 2'b00 : upd_entry - 2'b01;
            end
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update_valid_M) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_d = branch_cnt_q + 32'd1;
            end
            if ((update_taken_M != update_predicted_M) && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        redirect_valid_d = branch_redirect_M;
        redirect_pc_d    = branch_redirect_M ? branch_dest_M : redirect_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign redirect_valid_F = redirect_valid_q;
    assign redirect_pc_F    = redirect_pc_q;
    assign branch_cnt       = branch_cnt_q;
    assign mispredict_cnt   = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - scoreboard bench for branch_predictor_bht against a behavioural table model.
module tb_branch_predictor_bht;
    localparam int IB   = 6;
    localparam int NENT = 1 << IB;

    logic          clk = 1'b0;
    logic          rstn;
    logic [31:0]   pc_F;
    logic          pred_taken_F;
    logic [IB-1:0] pred_ghr_F;
    logic          update_valid_M;
    logic [31:0]   update_pc_M;
    logic          update_taken_M;
    logic          update_predicted_M;
    logic [IB-1:0] update_ghr_M;
    logic          branch_redirect_M;
    logic [31:0]   branch_dest_M;
    logic          redirect_valid_F;
    logic [31:0]   redirect_pc_F;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispredict_cnt;

    branch_predictor_bht #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rstn(rstn), .pc_F(pc_F), .pred_taken_F(pred_taken_F),
        .pred_ghr_F(pred_ghr_F), .update_valid_M(update_valid_M),
        .update_pc_M(update_pc_M), .update_taken_M(update_taken_M),
        .update_predicted_M(update_predicted_M), .update_ghr_M(update_ghr_M),
        .branch_redirect_M(branch_redirect_M), .branch_dest_M(branch_dest_M),
        .redirect_valid_F(redirect_valid_F), .redirect_pc_F(redirect_pc_F),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pred;
        logic [31:0] ghr;
        logic [31:0] bc;
        logic [31:0] mc;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rdq[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: counters as small integers, statistics as wide integers.
    int          m_tbl [NENT];
    int          m_ghr;
    longint      m_bc, m_mc;
    bit          m_rv;
    logic [31:0] m_rpc;
    bit          m_ok = 0;

    function automatic int idx_of(input logic [31:0] pc, input int hist);
        return ((pc >> 2) ^ hist) % NENT;
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_tbl[idx_of(pc, m_ghr)] >= 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_edge();
        int hist;
        if (!rstn) begin
            foreach (m_tbl[i]) m_tbl[i] = 1;
            m_ghr = 0; m_bc = 0; m_mc = 0; m_rv = 0; m_rpc = 0;
            m_ok  = 1;
            return;
        end
        if (update_valid_M) begin
`ifdef BRANCH_GSHARE_EN
            hist = int'(update_ghr_M);
            m_ghr = ((m_ghr << 1) | int'(update_taken_M)) % NENT;
`else
            hist = 0;
`endif
            if (update_taken_M) m_tbl[idx_of(update_pc_M, hist)] = (m_tbl[idx_of(update_pc_M, hist)] == 3) ? 3 : m_tbl[idx_of(update_pc_M, hist)] + 1;
            else                m_tbl[idx_of(update_pc_M, hist)] = (m_tbl[idx_of(update_pc_M, hist)] == 0) ? 0 : m_tbl[idx_of(update_pc_M, hist)] - 1;
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (update_taken_M != update_predicted_M && m_mc < 64'hFFFF_FFFF) m_mc++;
        end
        m_rv = branch_redirect_M;
        if (branch_redirect_M) m_rpc = branch_dest_M;
    endtask

    task automatic cyc(input bit rn, input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                       input bit ut, input bit up, input bit br, input logic [31:0] dest);
        exp_t e;
        rstn = rn; pc_F = pc; update_valid_M = uv; update_pc_M = upc;
        update_taken_M = ut; update_predicted_M = up;
        branch_redirect_M = br; branch_dest_M = dest;
`ifdef BRANCH_GSHARE_EN
        update_ghr_M = IB'(m_ghr);
`else
        update_ghr_M = IB'($urandom);
`endif
        if (m_ok) begin
            e.pred = m_pred(pc);
`ifdef BRANCH_GSHARE_EN
            e.ghr = 32'(m_ghr);
`else
            e.ghr = 32'd0;
`endif
            e.bc = m_bc[31:0]; e.mc = m_mc[31:0]; e.rv = m_rv; e.rpc = m_rpc;
            exp_q.push_back(e);
        end
        if (rn && br) rdq.push_back(dest);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        cyc(1, pc, 0, 32'hDEAD_BEEF, 1, 0, 0, 32'h1234_5678);
    endtask

    // Monitor: compares settled outputs mid-cycle; redirect targets are matched only when valid is presented.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pred_taken_F", 32'(pred_taken_F), 32'(e.pred));
            chk("pred_ghr_F", 32'(pred_ghr_F), e.ghr);
            chk("branch_cnt", branch_cnt, e.bc);
            chk("mispredict_cnt", mispredict_cnt, e.mc);
            chk("redirect_valid_F", 32'(redirect_valid_F), 32'(e.rv));
            chk("redirect_pc_F", redirect_pc_F, e.rpc);
        end
        if (redirect_valid_F === 1'b1 && m_ok) begin
            if (rdq.size() == 0) begin
                checks++; errors++;
                $display("FAIL redirect_unexpected: got %h expected none", redirect_pc_F);
            end else begin
                chk("redirect_target", redirect_pc_F, rdq.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] pc, upc;
        bit          t;
        cyc(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h4000);
        cyc(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0);
        idle(32'h100);
        cyc(1, 32'h100, 1, 32'h100, 1, 0, 0, 32'h0);
        cyc(1, 32'h100, 1, 32'h100, 1, 1, 0, 32'h0);
        idle(32'h100);
        cyc(1, 32'h104, 1, 32'h104, 0, 0, 0, 32'h0);
        cyc(1, 32'h104, 1, 32'h104, 0, 0, 0, 32'h0);
        cyc(1, 32'h104, 1, 32'h104, 0, 0, 0, 32'h0);
        idle(32'h104);
        cyc(1, 32'h100, 0, 32'h0, 0, 0, 1, 32'h2000);
        idle(32'h100);
        idle(32'h100);
        cyc(1, 32'h100, 1, 32'h100, 1, 1, 0, 32'h0);
        cyc(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h3000);
        idle(32'h100);
        idle(32'h100);
        for (int n = 0; n < 600; n++) begin
            pc  = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 4'h0, 6'($urandom_range(0, 15)), 2'($urandom)};
            upc = {20'($urandom), 4'h0, 6'($urandom_range(0, 15)), 2'b00};
            t   = $urandom_range(0, 3) != 0;
            cyc($urandom_range(0, 59) != 0, pc, $urandom_range(0, 2) != 0, upc, t,
                $urandom_range(0, 1) ? m_pred(upc) : 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom);
        end
        idle(32'h0);
        idle(32'h0);
        idle(32'h0);
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() != 0 || rdq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q.size(), rdq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
